// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity mode constants.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle registered tick every baud_div+1 clocks.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] baud_div,
  output logic        tick
);

  logic [15:0] r_cnt;
  logic        r_tick;

  // Divide-by-(baud_div+1) counter; clear restarts the phase from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == baud_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 16'd1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with parity/framing checks and a one-word output holding register.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVS         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rxd,
  input  logic [15:0]          baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = 4;
  localparam logic [TW-1:0] START_MID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_rx_ovs: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $fatal(1, "uart_rx_ovs: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_rx_ovs: STOP_BITS must be 1 or 2");
  end
  if (OVS != 8 && OVS != 16) begin : g_bad_ovs
    $fatal(1, "uart_rx_ovs: OVS must be 8 or 16");
  end

  rx_state_e            r_state;
  logic                 r_rxd_meta;
  logic                 r_rxd_sync;
  logic                 r_rxd_prev;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  logic w_tick;
  logic w_fall;
  logic w_bit_end;
  logic w_par_exp;

  // Tick phase is held at zero while idle so the first tick of a frame is aligned to the start edge.
  uart_baud_tick u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (r_state == ST_IDLE),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  assign w_fall    = r_rxd_prev & ~r_rxd_sync;
  assign w_bit_end = w_tick && (r_tick_cnt == BIT_END);
  assign w_par_exp = (PARITY_MODE == PAR_ODD) ? ~(^r_shift) : ^r_shift;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // Frame FSM, mid-bit sampling and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      r_frm_err     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_overrun_err <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (!rx_en) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            if (w_fall) begin
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (w_tick) begin
              if (r_tick_cnt == START_MID) begin
                r_tick_cnt <= '0;
                r_state    <= r_rxd_sync ? ST_IDLE : ST_DATA;
              end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
              end
            end
          end
          ST_DATA: begin
            if (w_bit_end) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rxd_sync, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == LAST_DATA) begin
                r_bit_cnt <= '0;
                r_state   <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          ST_PARITY: begin
            if (w_bit_end) begin
              r_tick_cnt <= '0;
              r_par_err  <= r_rxd_sync ^ w_par_exp;
              r_state    <= ST_STOP;
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (w_bit_end) begin
              r_tick_cnt <= '0;
              if (r_bit_cnt == LAST_STOP) begin
                r_state <= ST_IDLE;
                if (!r_rx_valid || rx_ready) begin
                  r_rx_data    <= r_shift;
                  r_parity_err <= r_par_err;
                  r_frame_err  <= r_frm_err | ~r_rxd_sync;
                  r_rx_valid   <= 1'b1;
                end else begin
                  r_overrun_err <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                r_frm_err <= r_frm_err | ~r_rxd_sync;
              end
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: default-config DUT A and even-parity DUT B.
module tb_uart_rx_ovs;

  // baud_div=3 -> 4 clk per tick, OVS=16 -> 64 clk per bit.
  localparam int BIT_CLKS = 64;
  // Line edge at P0: synchronizer+edge detect -> START at P3; registered tick k is consumed at
  // P3+5+4k; final stop sample is tick 7+16*9=151 -> P612, rx_valid visible after that edge.
  localparam int STOP_LAT = 612;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b1;
  logic        rxd_a = 1'b1;
  logic        rxd_b = 1'b1;
  logic        rx_ready = 1'b0;
  logic [15:0] baud_div = 16'd3;

  logic [7:0] a_data, b_data;
  logic a_valid, a_perr, a_ferr, a_ovr;
  logic b_valid, b_perr, b_ferr, b_ovr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_start = 0;
  int rise_cnt = 0, rise_cyc = 0, ovr_cnt = 0, ovr_cyc = 0;
  int base_rise, base_ovr;
  logic prev_v = 1'b0;

  uart_rx_ovs u_dut_a (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd_a), .baud_div(baud_div),
    .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rx_ready),
    .parity_err(a_perr), .frame_err(a_ferr), .overrun_err(a_ovr)
  );

  uart_rx_ovs #(.PARITY_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd_b), .baud_div(baud_div),
    .rx_data(b_data), .rx_valid(b_valid), .rx_ready(rx_ready),
    .parity_err(b_perr), .frame_err(b_ferr), .overrun_err(b_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record rx_valid rising edges and overrun pulses of DUT A.
  always @(negedge clk) begin
    if (a_valid && !prev_v) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (a_ovr) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    prev_v = a_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_b, input logic v);
    if (to_b) rxd_b = v;
    else rxd_a = v;
    step(BIT_CLKS);
  endtask

  task automatic send(input bit to_b, input logic [7:0] d, input bit use_par,
                      input logic par, input logic stop_v);
    step(1);
    t_start = cyc;
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
    if (use_par) drive_bit(to_b, par);
    drive_bit(to_b, stop_v);
    drive_bit(to_b, 1'b1);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    step(3);
    chk("reset_valid", 32'(a_valid), 32'd0);
    chk("reset_data", 32'(a_data), 32'd0);
    chk("reset_flags", {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
    rst = 1'b0;
    step(5);

    // Basic word and latency.
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_data", 32'(a_data), 32'hA5);
    chk("a5_valid", 32'(a_valid), 32'd1);
    chk("a5_flags", {30'd0, a_perr, a_ferr}, 32'd0);
    chk("a5_latency", 32'(rise_cyc - t_start), 32'(STOP_LAT));
    consume();
    chk("a5_consumed", 32'(a_valid), 32'd0);

    // Even parity: ^0x07 = 1, so parity bit 0 is wrong and 1 is right.
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("par0_data", 32'(b_data), 32'h07);
    chk("par0_perr", 32'(b_perr), 32'd1);
    consume();
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("par1_valid", 32'(b_valid), 32'd1);
    chk("par1_perr", 32'(b_perr), 32'd0);
    consume();

    // Framing error, then recovery.
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("frm_data", 32'(a_data), 32'h3C);
    chk("frm_ferr", 32'(a_ferr), 32'd1);
    consume();
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("frm_next_data", 32'(a_data), 32'h55);
    chk("frm_next_ferr", 32'(a_ferr), 32'd0);
    consume();

    // Overrun: consumer stalled across two words.
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    base_ovr = ovr_cnt;
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_data_kept", 32'(a_data), 32'h11);
    chk("ovr_valid", 32'(a_valid), 32'd1);
    chk("ovr_pulses", 32'(ovr_cnt - base_ovr), 32'd1);
    chk("ovr_timing", 32'(ovr_cyc - t_start), 32'(STOP_LAT));
    consume();

    // Short low glitch (3 ticks) is a false start.
    base_rise = rise_cnt;
    rxd_a = 1'b0;
    step(12);
    rxd_a = 1'b1;
    step(12 * BIT_CLKS);
    chk("glitch_valid", 32'(a_valid), 32'd0);
    chk("glitch_words", 32'(rise_cnt - base_rise), 32'd0);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("glitch_recover", 32'(a_data), 32'h5A);
    consume();

    // rx_en drop mid-frame aborts without a word.
    base_rise = rise_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    rx_en = 1'b0;
    step(2);
    rxd_a = 1'b1;
    rx_en = 1'b1;
    step(12 * BIT_CLKS);
    chk("abort_words", 32'(rise_cnt - base_rise), 32'd0);
    chk("abort_flags", {29'd0, a_valid, a_ferr, a_ovr}, 32'd0);

    // Reset during bit 4 of 0x96, then 0x69 decodes cleanly.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'((8'h96 >> i) & 8'h01));
    rxd_a = 1'b1;
    step(20);
    rst = 1'b1;
    step(3);
    chk("rst_mid_valid", 32'(a_valid), 32'd0);
    chk("rst_mid_data", 32'(a_data), 32'd0);
    rst = 1'b0;
    base_rise = rise_cnt;
    step(BIT_CLKS);
    send(1'b0, 8'h69, 1'b0, 1'b0, 1'b1);
    chk("post_rst_data", 32'(a_data), 32'h69);
    chk("post_rst_words", 32'(rise_cnt - base_rise), 32'd1);
    chk("post_rst_flags", {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
